// File: rtl/serial_adder_cs303.sv
// serial_adder_cs303: multi-cycle adder that sums two WIDTH-bit operands plus a
// carry-in, DIGIT bits per clock, behind a start/busy/done handshake.
// Each digit is a ripple chain of FA_cs303 full adders. The carry is registered
// between digits.
// Optional feature macro: SIGNED_OVF_EN adds the o_ovf signed-overflow output.

module FA_cs303 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_cs303 #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef SIGNED_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int STEPS = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("serial_adder_cs303: illegal WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [DIGIT:0]         w_c;
  logic [DIGIT-1:0]       w_dsum;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_sum_nxt;

  // Digit datapath: ripple chain seeded by the registered inter-digit carry.
  assign w_c[0] = r_carry;
  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    FA_cs303 u_fa (
      .i_a (r_a[g]),
      .i_b (r_b[g]),
      .i_c (w_c[g]),
      .o_s (w_dsum[g]),
      .o_c (w_c[g+1])
    );
  end

  // New digit enters sum at the MSB end; after STEPS shifts the LSB digit lands at bit 0.
  assign w_cat     = {w_dsum, r_sum};
  assign w_sum_nxt = w_cat[WIDTH+DIGIT-1:DIGIT];

  // Next-state logic and datapath enables for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake flags registered from the next state so they align with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  // Operand capture on accept, then one digit per clock while running.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= w_sum_nxt;
      r_carry <= w_c[DIGIT];
      r_cnt   <= r_cnt + CW'(1'b1);
      if (w_last) begin
        r_cout <= w_c[DIGIT];
      end
    end
  end

`ifdef SIGNED_OVF_EN
  logic r_ovf;

  // Signed overflow of the final digit: carry into the MSB differs from carry out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (w_step && w_last) begin
      r_ovf <= w_c[DIGIT] ^ w_c[DIGIT-1];
    end
  end

  assign o_ovf = r_ovf;
`endif

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder_cs303.sv
// Bench for serial_adder_cs303: three instances (8/1, 8/4, 4/2) share one
// stimulus stream; a per-instance reference model predicts acceptance and
// results, which are queued on accept and compared when done pulses.

module tb_serial_adder_cs303;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;

  logic       busy0, done0, cout0, ovf0;
  logic [7:0] sum0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy2, done2, cout2, ovf2;
  logic [3:0] sum2;

  serial_adder_cs303 #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy0), .o_done(done0), .o_sum(sum0), .o_cout(cout0)
`ifdef SIGNED_OVF_EN
    , .o_ovf(ovf0)
`endif
  );

  serial_adder_cs303 #(.WIDTH(8), .DIGIT(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1)
`ifdef SIGNED_OVF_EN
    , .o_ovf(ovf1)
`endif
  );

  serial_adder_cs303 #(.WIDTH(4), .DIGIT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a[3:0]), .i_b(b[3:0]), .i_cin(cin),
    .o_busy(busy2), .o_done(done2), .o_sum(sum2), .o_cout(cout2)
`ifdef SIGNED_OVF_EN
    , .o_ovf(ovf2)
`endif
  );

`ifndef SIGNED_OVF_EN
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   m_cnt [3];
  exp_t last_r [3];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [7:0] x, input logic [7:0] y,
                                 input logic c);
    exp_t       e;
    logic [8:0] full;
    logic [7:0] mask;
    mask   = (w == 8) ? 8'hFF : 8'h0F;
    full   = {1'b0, x & mask} + {1'b0, y & mask} + {8'd0, c};
    e.sum  = full[7:0] & mask;
    e.cout = full[w];
    e.ovf  = (x[w-1] == y[w-1]) && (e.sum[w-1] != x[w-1]);
    return e;
  endfunction

  // Reference handshake: busy for steps+1 cycles after an accept, done in the last.
  task automatic edge_model(input int id, input int w, input int steps);
    exp_t e;
    if (rst) begin
      m_cnt[id]  = 0;
      last_r[id] = '0;
      case (id)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
    end else if (m_cnt[id] == 0) begin
      if (start) begin
        e = model(w, a, b, cin);
        case (id)
          0:       q0.push_back(e);
          1:       q1.push_back(e);
          default: q2.push_back(e);
        endcase
        m_cnt[id] = steps + 1;
      end
    end else begin
      m_cnt[id] = m_cnt[id] - 1;
    end
  endtask

  task automatic check_outs(input int id, input logic busy, input logic done, input int sum,
                            input logic cout, input logic ovf);
    exp_t  e;
    int    n;
    string p;
    p = $sformatf("u%0d", id);
    check_val({p, "_busy"}, 32'(busy), (m_cnt[id] > 0) ? 1 : 0);
    check_val({p, "_done"}, 32'(done), (m_cnt[id] == 1) ? 1 : 0);
    if (done) begin
      case (id)
        0:       n = q0.size();
        1:       n = q1.size();
        default: n = q2.size();
      endcase
      check_val({p, "_sb_pending"}, (n > 0) ? 1 : 0, 1);
      if (n > 0) begin
        case (id)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        last_r[id] = e;
      end
    end
    if (done || m_cnt[id] == 0) begin
      check_val({p, "_sum"}, sum, 32'(last_r[id].sum));
      check_val({p, "_cout"}, 32'(cout), 32'(last_r[id].cout));
`ifdef SIGNED_OVF_EN
      check_val({p, "_ovf"}, 32'(ovf), 32'(last_r[id].ovf));
`endif
    end
  endtask

  // Monitor: advance the models on the edge, compare DUT outputs 1 time unit later.
  always @(posedge clk) begin
    edge_model(0, 8, 8);
    edge_model(1, 8, 2);
    edge_model(2, 4, 2);
    #1;
    check_outs(0, busy0, done0, 32'(sum0), cout0, ovf0);
    check_outs(1, busy1, done1, 32'(sum1), cout1, ovf1);
    check_outs(2, busy2, done2, 32'(sum2), cout2, ovf2);
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_cnt[0] != 0 || m_cnt[1] != 0 || m_cnt[2] != 0) && k < 40) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 40) check_val("idle_timeout", k, 39);
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    wait_idle();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;

    do_op(8'h00, 8'h00, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0);
    do_op(8'h80, 8'h80, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1);

    // start held high with operands changing every cycle
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      @(posedge clk);
      #2;
    end
    start = 1'b0;
    wait_idle();

    // reset on the 4th RUN edge aborts the operation
    a     = 8'h9C;
    b     = 8'h3B;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    do_op(8'h12, 8'h34, 1'b0);

    // exhaustive over the low nibble (full space of the 4/2 instance)
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          do_op({4'($urandom), 4'(x)}, {4'($urandom), 4'(y)}, 1'(c));
        end
      end
    end

    check_val("u0_sb_left", q0.size(), 0);
    check_val("u1_sb_left", q1.size(), 0);
    check_val("u2_sb_left", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
